// File: rtl/count_pkg.sv
// Shared constants for the count_sched scheduler: FSM state encodings,
// default counter width and number of clients.
package count_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int DEFAULT_WIDTH = 4;
  localparam int CLIENTS       = 2;

endpackage

// File: rtl/count_sched_mod_counter.sv
// WIDTH-bit event counter with synchronous clear and enable; hit flags that
// the enabled increment is about to land on the terminal count.
module mod_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] tc,
  output logic [WIDTH-1:0] count,
  output logic             hit
);

  logic [WIDTH:0] count_inc;

  // One extra bit so an all-ones count can never alias a small terminal value.
  assign count_inc = {1'b0, count} + (WIDTH+1)'(1);
  assign hit       = enable && (count_inc == {1'b0, tc});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count_inc[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/count_sched.sv
// Two-client round-robin scheduler sharing one modulo event counter; the
// owner's terminal count is latched at LOAD and done pulses on completion.
module count_sched
  import count_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] tc0,
  input  logic [WIDTH-1:0] tc1,
  input  logic             x,
  input  logic             abort,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       done
);

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic             owner_reg;
  logic             last_reg;
  logic [WIDTH-1:0] tc_q;
  logic [WIDTH-1:0] tc_sel;
  logic             pick;
  logic             clear;
  logic             enable;
  logic             hit;

  // Both requesting: the client that did not win last time goes next.
  assign pick   = (req == 2'b11) ? ~last_reg : req[1];
  assign tc_sel = owner_reg ? tc1 : tc0;

  // Abort freezes the counter, so the aborted value stays visible.
  assign clear  = (state_reg == LOAD) && !abort;
  assign enable = (state_reg == COUNT) && x && !abort;

  mod_counter #(.WIDTH(WIDTH)) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .enable (enable),
    .tc     (tc_q),
    .count  (count),
    .hit    (hit)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req != 2'b00) state_next = LOAD;
      LOAD: begin
        if (abort)                state_next = IDLE;
        else if (tc_sel == '0)    state_next = DONE;
        else                      state_next = COUNT;
      end
      COUNT: begin
        if (abort)                state_next = IDLE;
        else if (hit)             state_next = DONE;
      end
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      tc_q      <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req != 2'b00) begin
        owner_reg <= pick;
        last_reg  <= pick;
      end
      if (state_reg == LOAD) begin
        tc_q <= tc_sel;
      end
    end
  end

  assign busy = (state_reg != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < CLIENTS; gi++) begin : g_client
      assign grant[gi] = busy && (owner_reg == 1'(gi));
      assign done[gi]  = (state_reg == DONE) && (owner_reg == 1'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched: single job, gapped events, contention,
// zero terminal, abort and asynchronous reset mid-count.
module tb_count_sched;

  logic       clock;
  logic       reset;
  logic [1:0] req;
  logic [3:0] tc0;
  logic [3:0] tc1;
  logic       x;
  logic       abort;
  logic [1:0] grant;
  logic       busy;
  logic [3:0] count;
  logic [1:0] done;

  int errors = 0;
  int checks = 0;

  count_sched #(.WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .tc0   (tc0),
    .tc1   (tc1),
    .x     (x),
    .abort (abort),
    .grant (grant),
    .busy  (busy),
    .count (count),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0; req = 2'b00; tc0 = 4'd0; tc1 = 4'd0; x = 1'b0; abort = 1'b0;
    #12;
    chk("rst_grant", 8'(grant), 8'h0);
    chk("rst_busy",  8'(busy),  8'h0);
    chk("rst_count", 8'(count), 8'h0);
    chk("rst_done",  8'(done),  8'h0);
    tick();
    reset = 1'b1;
    tick();

    // Single job: tc0=3, x held high.
    req = 2'b01; tc0 = 4'd3; x = 1'b1;
    tick();
    chk("s_load_grant", 8'(grant), 8'h1);
    chk("s_load_busy",  8'(busy),  8'h1);
    req = 2'b00;
    tick();
    chk("s_count0", 8'(count), 8'h0);
    tick(); chk("s_count1", 8'(count), 8'h1);
    tick(); chk("s_count2", 8'(count), 8'h2);
    chk("s_nodone", 8'(done), 8'h0);
    tick(); chk("s_count3", 8'(count), 8'h3);
    chk("s_done",  8'(done),  8'h1);
    chk("s_dgrant", 8'(grant), 8'h1);
    tick();
    chk("s_done_off", 8'(done),  8'h0);
    chk("s_grant_off", 8'(grant), 8'h0);
    chk("s_count_hold", 8'(count), 8'h3);

    // Gapped events: tc1=2, x pattern 1,0,0,1.
    req = 2'b10; tc1 = 4'd2; x = 1'b0;
    tick();
    chk("g_grant", 8'(grant), 8'h2);
    req = 2'b00;
    tick();
    chk("g_count0", 8'(count), 8'h0);
    x = 1'b1; tick(); chk("g_cnt_a", 8'(count), 8'h1);
    x = 1'b0; tick(); chk("g_cnt_b", 8'(count), 8'h1);
    tick(); chk("g_cnt_c", 8'(count), 8'h1);
    chk("g_nodone", 8'(done), 8'h0);
    x = 1'b1; tick(); chk("g_cnt_d", 8'(count), 8'h2);
    chk("g_done", 8'(done), 8'h2);
    x = 1'b0;
    tick();

    // Contention: req=11 held; last was client 1, so 0,1,0.
    req = 2'b11; tc0 = 4'd1; tc1 = 4'd1; x = 1'b1;
    for (int j = 0; j < 3; j++) begin
      logic [1:0] exp_g;
      exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
      tick(); chk("c_grant", 8'(grant), 8'(exp_g));
      tick(); chk("c_busy_count", 8'(busy), 8'h1);
      tick(); chk("c_done", 8'(done), 8'(exp_g));
      tick(); chk("c_idle_grant", 8'(grant), 8'h0);
    end
    req = 2'b00; x = 1'b0;
    tick();

    // Zero terminal: LOAD then DONE.
    req = 2'b01; tc0 = 4'd0;
    tick();
    chk("z_grant", 8'(grant), 8'h1);
    chk("z_nodone", 8'(done), 8'h0);
    req = 2'b00;
    tick();
    chk("z_done",  8'(done),  8'h1);
    chk("z_count", 8'(count), 8'h0);
    tick();
    chk("z_idle", 8'(busy), 8'h0);

    // Abort when count reaches 4 with x still high: the increment is suppressed.
    req = 2'b01; tc0 = 4'd9; x = 1'b1;
    tick();
    req = 2'b00;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("a_count", 8'(count), 8'(k));
      chk("a_nodone", 8'(done), 8'h0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("a_busy",  8'(busy),  8'h0);
    chk("a_hold",  8'(count), 8'h4);
    chk("a_done",  8'(done),  8'h0);
    req = 2'b11; tc1 = 4'd5;
    tick();
    chk("a_rr_grant", 8'(grant), 8'h2);
    req = 2'b00;

    // Async reset during COUNT.
    tick();
    tick();
    tick();
    chk("r_pre_count", 8'(count), 8'h2);
    #2 reset = 1'b0;
    #1;
    chk("r_grant", 8'(grant), 8'h0);
    chk("r_busy",  8'(busy),  8'h0);
    chk("r_count", 8'(count), 8'h0);
    chk("r_done",  8'(done),  8'h0);
    tick();
    reset = 1'b1;
    req = 2'b11;
    tick();
    chk("r_first_grant", 8'(grant), 8'h1);
    req = 2'b00; x = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
